// File: rtl/rbt_hdr_rr_arbiter.sv
// rtl/rbt_hdr_rr_arbiter.sv - round-robin arbiter merging per-port header streams into one registered stream
module rbt_hdr_rr_arbiter #(
  parameter int PORTS              = 4,
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = 272
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORTS-1:0]                    port_enable,
  input  logic [PORTS-1:0]                    s_hdr_valid,
  output logic [PORTS-1:0]                    s_hdr_ready,
  input  logic [PORTS*HEADER_WIDTH-1:0]       s_hdr_data,
  input  logic [PORTS*16-1:0]                 s_hdr_length,
  input  logic [PORTS*PKT_METADATA_WIDTH-1:0] s_hdr_pkt_metadata,
  output logic                                m_hdr_valid,
  input  logic                                m_hdr_ready,
  output logic [HEADER_WIDTH-1:0]             m_hdr_data,
  output logic [15:0]                         m_hdr_length,
  output logic [PKT_METADATA_WIDTH-1:0]       m_hdr_pkt_metadata,
  output logic [$clog2(PORTS)-1:0]            m_hdr_port,
  output logic [PORTS*16-1:0]                 accept_count
);

  localparam int PW = $clog2(PORTS);

  logic [HEADER_WIDTH-1:0]       hdr_arr  [PORTS];
  logic [15:0]                   len_arr  [PORTS];
  logic [PKT_METADATA_WIDTH-1:0] meta_arr [PORTS];

  logic [PORTS-1:0] eligible;
  logic             grant_vld;
  logic [PW-1:0]    grant_idx;
  logic             load_ok;
  logic             accept;

  logic                          valid_q, valid_d;
  logic [HEADER_WIDTH-1:0]       data_q, data_d;
  logic [15:0]                   len_q, len_d;
  logic [PKT_METADATA_WIDTH-1:0] meta_q, meta_d;
  logic [PW-1:0]                 port_q, port_d;
  logic [PW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [15:0]                   cnt_q [PORTS];
  logic [15:0]                   cnt_d [PORTS];

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      hdr_arr[i]  = s_hdr_data[i*HEADER_WIDTH +: HEADER_WIDTH];
      len_arr[i]  = s_hdr_length[i*16 +: 16];
      meta_arr[i] = s_hdr_pkt_metadata[i*PKT_METADATA_WIDTH +: PKT_METADATA_WIDTH];
    end
  end

  assign eligible = s_hdr_valid & port_enable;
  assign load_ok  = !valid_q || m_hdr_ready;
  // Gating with rst keeps every ready low while reset is held, even mid-cycle.
  assign accept   = grant_vld && load_ok && rst;

  // Circular search from rr_ptr; the index wraps explicitly so non-power-of-two PORTS work.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    s_hdr_ready = '0;
    if (accept) s_hdr_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    len_d    = len_q;
    meta_d   = meta_q;
    port_d   = port_q;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < PORTS; i++) cnt_d[i] = cnt_q[i];
    if (accept) begin
      valid_d  = 1'b1;
      data_d   = hdr_arr[grant_idx];
      len_d    = len_arr[grant_idx];
      meta_d   = meta_arr[grant_idx];
      port_d   = grant_idx;
      rr_ptr_d = (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
      if (cnt_q[grant_idx] != 16'hFFFF) cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
    end else if (m_hdr_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      len_q    <= '0;
      meta_q   <= '0;
      port_q   <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      len_q    <= len_d;
      meta_q   <= meta_d;
      port_q   <= port_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign m_hdr_valid        = valid_q;
  assign m_hdr_data         = data_q;
  assign m_hdr_length       = len_q;
  assign m_hdr_pkt_metadata = meta_q;
  assign m_hdr_port         = port_q;

  always_comb begin
    for (int i = 0; i < PORTS; i++) accept_count[i*16 +: 16] = cnt_q[i];
  end

endmodule

// File: tb/tb_rbt_hdr_rr_arbiter.sv
// tb/tb_rbt_hdr_rr_arbiter.sv - directed-vector bench for rbt_hdr_rr_arbiter (4-port and 3-port instances)
module tb_rbt_hdr_rr_arbiter;

  localparam int HW  = 64;
  localparam int MW  = 24;
  localparam int HW3 = 8;
  localparam int MW3 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      en4, v4, s_rdy4;
  logic [4*HW-1:0] d4;
  logic [4*16-1:0] l4;
  logic [4*MW-1:0] md4;
  logic            m_vld4, m_rdy4;
  logic [HW-1:0]   m_data4;
  logic [15:0]     m_len4;
  logic [MW-1:0]   m_meta4;
  logic [1:0]      m_port4;
  logic [4*16-1:0] acc4;

  logic [2:0]       en3, v3, s_rdy3;
  logic [3*HW3-1:0] d3;
  logic [3*16-1:0]  l3;
  logic [3*MW3-1:0] md3;
  logic             m_vld3, m_rdy3;
  logic [HW3-1:0]   m_data3;
  logic [15:0]      m_len3;
  logic [MW3-1:0]   m_meta3;
  logic [1:0]       m_port3;
  logic [3*16-1:0]  acc3;

  int checks   = 0;
  int failures = 0;

  rbt_hdr_rr_arbiter #(.PORTS(4), .HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW)) dut4 (
    .clk(clk), .rst(rst), .port_enable(en4), .s_hdr_valid(v4), .s_hdr_ready(s_rdy4),
    .s_hdr_data(d4), .s_hdr_length(l4), .s_hdr_pkt_metadata(md4),
    .m_hdr_valid(m_vld4), .m_hdr_ready(m_rdy4), .m_hdr_data(m_data4), .m_hdr_length(m_len4),
    .m_hdr_pkt_metadata(m_meta4), .m_hdr_port(m_port4), .accept_count(acc4)
  );

  rbt_hdr_rr_arbiter #(.PORTS(3), .HEADER_WIDTH(HW3), .PKT_METADATA_WIDTH(MW3)) dut3 (
    .clk(clk), .rst(rst), .port_enable(en3), .s_hdr_valid(v3), .s_hdr_ready(s_rdy3),
    .s_hdr_data(d3), .s_hdr_length(l3), .s_hdr_pkt_metadata(md3),
    .m_hdr_valid(m_vld3), .m_hdr_ready(m_rdy3), .m_hdr_data(m_data3), .m_hdr_length(m_len3),
    .m_hdr_pkt_metadata(m_meta3), .m_hdr_port(m_port3), .accept_count(acc3)
  );

  function automatic logic [HW-1:0] hdr_of(input int i);
    logic [7:0] b;
    b = 8'hA0 + 8'(i);
    return {8{b}};
  endfunction

  function automatic logic [15:0] len_of(input int i);
    return 16'(100 + i);
  endfunction

  function automatic logic [MW-1:0] meta_of(input int i);
    return 24'hC0FFE0 + 24'(i);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    en4 = 4'hF; v4 = 4'hF; m_rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d4[i*HW +: HW]  = hdr_of(i);
      l4[i*16 +: 16]  = len_of(i);
      md4[i*MW +: MW] = meta_of(i);
    end
    en3 = 3'b111; v3 = 3'b000; m_rdy3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d3[i*HW3 +: HW3]  = 8'h30 + 8'(i);
      l3[i*16 +: 16]    = 16'(i);
      md3[i*MW3 +: MW3] = 8'h50 + 8'(i);
    end

    // Reset state with every port requesting
    #2;
    check_eq("rst_valid", 64'(m_vld4), 64'd0);
    check_eq("rst_ready", 64'(s_rdy4), 64'd0);
    check_eq("rst_port", 64'(m_port4), 64'd0);
    check_eq("rst_data", 64'(m_data4), 64'd0);
    check_eq("rst_len", 64'(m_len4), 64'd0);
    check_eq("rst_acc", acc4, 64'd0);
    tick();

    // All ports valid, sink always ready: 0,1,2,3,0,... one beat per cycle
    rst = 1'b1;
    #1;
    check_eq("rr_first_ready", 64'(s_rdy4), 64'b0001);
    check_eq("rr_no_valid_yet", 64'(m_vld4), 64'd0);
    for (int n = 0; n < 8; n++) begin
      tick();
      check_eq("rr_valid", 64'(m_vld4), 64'd1);
      check_eq("rr_port", 64'(m_port4), 64'(n % 4));
      check_eq("rr_data", 64'(m_data4), 64'(hdr_of(n % 4)));
      check_eq("rr_len", 64'(m_len4), 64'(len_of(n % 4)));
      check_eq("rr_meta", 64'(m_meta4), 64'(meta_of(n % 4)));
      check_eq("rr_ready", 64'(s_rdy4), 64'(1 << ((n + 1) % 4)));
    end
    for (int i = 0; i < 4; i++) check_eq("rr_acc", 64'(acc4[i*16 +: 16]), 64'd2);
    v4 = 4'b0000;
    #1;
    check_eq("idle_ready", 64'(s_rdy4), 64'd0);
    tick();
    check_eq("drain_clears_valid", 64'(m_vld4), 64'd0);

    // Single port 2, sink stalled five cycles
    v4 = 4'b0100;
    l4[2*16 +: 16] = 16'd74;
    m_rdy4 = 1'b0;
    #1;
    check_eq("p2_ready_empty_reg", 64'(s_rdy4), 64'b0100);
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("hold_valid", 64'(m_vld4), 64'd1);
      check_eq("hold_len", 64'(m_len4), 64'd74);
      check_eq("hold_port", 64'(m_port4), 64'd2);
      check_eq("hold_ready_low", 64'(s_rdy4), 64'd0);
      tick();
    end
    m_rdy4 = 1'b1;
    v4 = 4'b0000;
    #1;
    check_eq("hold_before_drain", 64'(m_len4), 64'd74);
    tick();
    check_eq("p2_drained", 64'(m_vld4), 64'd0);
    check_eq("p2_one_accept", 64'(acc4[2*16 +: 16]), 64'd3);
    l4[2*16 +: 16] = len_of(2);

    // Port 3 masked off; only port 1 may win
    do_reset();
    v4 = 4'b1010;
    en4 = 4'b0111;
    #1;
    check_eq("mask_ready", 64'(s_rdy4), 64'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("mask_port", 64'(m_port4), 64'd1);
      check_eq("mask_ready_cyc", 64'(s_rdy4), 64'b0010);
    end
    check_eq("mask_acc1", 64'(acc4[1*16 +: 16]), 64'd3);
    check_eq("mask_acc3", 64'(acc4[3*16 +: 16]), 64'd0);
    en4 = 4'b1111;
    #1;
    check_eq("unmask_ready", 64'(s_rdy4), 64'b1000);
    tick();
    check_eq("unmask_port", 64'(m_port4), 64'd3);

    // Asynchronous reset mid-cycle while a beat is held
    m_rdy4 = 1'b0;
    #1;
    check_eq("pre_rst_valid", 64'(m_vld4), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(m_vld4), 64'd0);
    check_eq("async_rst_port", 64'(m_port4), 64'd0);
    check_eq("async_rst_data", 64'(m_data4), 64'd0);
    check_eq("async_rst_acc", acc4, 64'd0);
    check_eq("async_rst_ready", 64'(s_rdy4), 64'd0);
    tick();
    rst = 1'b1;
    v4 = 4'b0101;
    m_rdy4 = 1'b1;
    #1;
    check_eq("post_rst_ready", 64'(s_rdy4), 64'b0001);
    tick();
    check_eq("post_rst_port", 64'(m_port4), 64'd0);
    check_eq("post_rst_next", 64'(s_rdy4), 64'b0100);

    // Empty eligible set: no ready, counters frozen
    v4 = 4'b0000;
    #1;
    check_eq("empty_ready", 64'(s_rdy4), 64'd0);
    tick();
    tick();
    check_eq("empty_valid", 64'(m_vld4), 64'd0);
    check_eq("empty_acc0", 64'(acc4[0 +: 16]), 64'd1);

    // Counter saturation
    do_reset();
    v4 = 4'b0001;
    repeat (65534) tick();
    check_eq("sat_fffe", 64'(acc4[0 +: 16]), 64'hFFFE);
    tick();
    check_eq("sat_ffff", 64'(acc4[0 +: 16]), 64'hFFFF);
    repeat (3) tick();
    check_eq("sat_hold", 64'(acc4[0 +: 16]), 64'hFFFF);
    check_eq("sat_acc1", 64'(acc4[1*16 +: 16]), 64'd0);
    check_eq("sat_port", 64'(m_port4), 64'd0);
    v4 = 4'b0000;

    // Three ports: pointer wraps 2 -> 0 and never reaches 3
    do_reset();
    v3 = 3'b111;
    #1;
    check_eq("p3_first_ready", 64'(s_rdy3), 64'b001);
    for (int n = 0; n < 7; n++) begin
      tick();
      check_eq("p3_port", 64'(m_port3), 64'(n % 3));
      check_eq("p3_data", 64'(m_data3), 64'(8'h30 + 8'(n % 3)));
      check_eq("p3_rr_ptr", 64'(dut3.rr_ptr_q), 64'((n + 1) % 3));
      check_eq("p3_ready", 64'(s_rdy3), 64'(1 << ((n + 1) % 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rbt_hdr_rr_arbiter.md
RBT_HDR_RR_ARBITER -- requirements
Module: rbt_hdr_rr_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of requesting header streams (2..8).
REQ-002 SHALL have parameter HEADER_WIDTH, default 2048: header bus width in bits.
REQ-003 SHALL have parameter PKT_METADATA_WIDTH, default 272: metadata width in bits.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port port_enable, input, PORTS: per-port arbitration enable mask.
REQ-007 SHALL have port s_hdr_valid, input, PORTS: per-port header valid.
REQ-008 SHALL have port s_hdr_ready, output, PORTS: per-port header ready.
REQ-009 SHALL have port s_hdr_data, input, PORTS*HEADER_WIDTH: headers; port i occupies slice [i*HEADER_WIDTH +: HEADER_WIDTH].
REQ-010 SHALL have port s_hdr_length, input, PORTS*16: header lengths, 16 bits per port.
REQ-011 SHALL have port s_hdr_pkt_metadata, input, PORTS*PKT_METADATA_WIDTH: metadata, one slice per port.
REQ-012 SHALL have ports m_hdr_valid (output, 1), m_hdr_ready (input, 1), m_hdr_data (output, HEADER_WIDTH), m_hdr_length (output, 16) and m_hdr_pkt_metadata (output, PKT_METADATA_WIDTH): the shared stream into the parser.
REQ-013 SHALL have port m_hdr_port, output, clog2(PORTS): source port of the current m_hdr beat.
REQ-014 SHALL have port accept_count, output, PORTS*16: per-port count of accepted headers.

Function
REQ-015 Output register SHALL be able to load when !m_hdr_valid | m_hdr_ready ("load_ok").
REQ-016 Eligible set SHALL be s_hdr_valid & port_enable.
REQ-017 Grant SHALL go to the first eligible port in circular order starting at rr_ptr.
REQ-018 Grant SHALL be combinational in the same cycle.
REQ-019 s_hdr_ready[i] SHALL be 1 only when i is granted and load_ok; at most one bit is set per cycle.
REQ-020 An accept on port i SHALL load data, length, metadata and m_hdr_port=i into the output register and set m_hdr_valid=1 on the next edge (latency 1 cycle).
REQ-021 On an accept on port i, rr_ptr SHALL become (i+1) mod PORTS.
REQ-022 rr_ptr SHALL be unchanged when there is no accept.
REQ-023 m_hdr_valid & m_hdr_ready with no new accept SHALL clear m_hdr_valid next cycle.
REQ-024 Drain and accept in the same cycle SHALL keep m_hdr_valid=1 and load the new beat; sustained throughput SHALL be 1 header/cycle.
REQ-025 m_hdr_* outputs SHALL hold stable while m_hdr_valid=1 and m_hdr_ready=0.
REQ-026 A port deasserting valid while not granted SHALL NOT be accepted; no state SHALL change for it.
REQ-027 Clearing port_enable[i] SHALL remove port i from the next grant decision.
REQ-028 Clearing port_enable[i] SHALL NOT affect a beat already held in the output register.
REQ-029 Empty eligible set SHALL mean no s_hdr_ready is set and no state changes.
REQ-030 accept_count[i] SHALL increment by 1 per accept on port i.
REQ-031 accept_count[i] SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-032 PORTS not a power of two SHALL wrap rr_ptr from PORTS-1 to 0; rr_ptr SHALL never hold a value >= PORTS.
REQ-033 Metadata SHALL pass through unmodified; this block SHALL NOT inspect header contents.

Reset
REQ-034 When rst=0, asynchronously: m_hdr_valid=0, m_hdr_data=0, m_hdr_length=0, m_hdr_pkt_metadata=0, m_hdr_port=0, rr_ptr=0, accept_count all 0.
REQ-035 s_hdr_ready SHALL be all 0 while rst=0.
REQ-036 Reset asserted mid-transfer SHALL discard the held beat; no partial output SHALL appear after release.
REQ-037 The first grant after release SHALL start from port 0.

Verification
REQ-038 Scenario: PORTS=4, all enabled, all valid, m_hdr_ready=1 -> m_hdr_port sequence 0,1,2,3,0..., one beat per cycle, first m_hdr_valid one cycle after the first accept.
REQ-039 Scenario: only port 2 valid, length 16'd74, m_hdr_ready=0 for 5 cycles -> exactly one accept; m_hdr_length=74 and m_hdr_port=2 held for 5 cycles; s_hdr_ready[2]=0 until the drain.
REQ-040 Scenario: ports 1 and 3 valid, port_enable=4'b0111 -> only port 1 is granted; port 3 is never ready; accept_count[3]=0.
REQ-041 Scenario: force accept_count[0] to 16'hFFFE, then two port-0 accepts -> accept_count[0]=16'hFFFF and stays there.
REQ-042 Scenario: rst driven low between clock edges while m_hdr_valid=1 -> m_hdr_valid=0 immediately, without waiting for an edge; after release with ports 2 and 0 valid, port 0 is granted first.
REQ-043 Scenario: PORTS=3 with all valid -> grant order 0,1,2,0; rr_ptr never equals 3.
